// File: rtl/seq_divider_8_by_4.sv
// Restoring divider: one quotient bit per clock behind start/busy/done.
// Divide-by-zero finishes immediately with an all-ones quotient.
module seq_divider_8_by_4 #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(DVD_W + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVS_W:0]   pr_q, pr_d;
  logic [DVD_W-1:0] sr_q, sr_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [DVS_W:0]   pr_sh;
  logic [DVS_W+1:0] trial;
  logic [DVS_W:0]   pr_nx;
  logic [DVD_W-1:0] sr_nx;
  logic             qbit;

  // The extra top bit of trial is the borrow of PR' - divisor.
  always_comb begin
    pr_sh = {pr_q[DVS_W-1:0], sr_q[DVD_W-1]};
    trial = {1'b0, pr_sh} - {2'b00, dvs_q};
    qbit  = ~trial[DVS_W+1];
    pr_nx = qbit ? trial[DVS_W:0] : pr_sh;
    sr_nx = {sr_q[DVD_W-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    sr_d    = sr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_d = 1'b1;
            quo_d  = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
          end else begin
            sr_d    = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            cnt_d   = CW'(DVD_W);
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        pr_d  = pr_nx;
        sr_d  = sr_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          quo_d   = sr_nx;
          rem_d   = pr_nx[DVS_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      sr_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      sr_q    <= sr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
